// File: rtl/sync_pulse_sender_pkg.sv
// sync_pulse_sender_pkg: shared FSM state type and synchronizer depth limits for the toggle CDC link
package sync_pulse_sender_pkg;
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/sync_pulse_sender_if.sv
// sync_pulse_sender_if: request/data/echo bundle between a toggle sender and its user/destination
interface sync_pulse_sender_if #(
  parameter int WIDTH = 16
) ();
  logic             send;
  logic [WIDTH-1:0] data;
  logic             accepted;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             req_toggle;
  logic [WIDTH-1:0] tx_data;
  logic             ack_toggle;
  modport master (
    input  send, data, ack_toggle,
    output accepted, busy, done, overflow, req_toggle, tx_data
  );
  modport slave (
    output send, data, ack_toggle,
    input  accepted, busy, done, overflow, req_toggle, tx_data
  );
endinterface

// File: rtl/sync_pulse_sender_bit_sync_chain.sv
// bit_sync_chain: resettable flop chain for a single asynchronous bit, depth clamped to the legal range
module bit_sync_chain
  import sync_pulse_sender_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_pre
);
  localparam int N = (STAGES < SYNC_MIN) ? SYNC_MIN : (STAGES > SYNC_MAX) ? SYNC_MAX : STAGES;
  logic [N-1:0] r;
  always_ff @(posedge clk) begin
    r <= reset ? '0 : {r[N-2:0], d};
  end
  // q_pre is what q becomes next cycle, letting the caller register a pulse that lines up with q
  assign q     = r[N-1];
  assign q_pre = r[N-2];
endmodule

// File: rtl/sync_pulse_sender.sv
// sync_pulse_sender: source end of a two-phase toggle CDC link with a one-word pending slot
module sync_pulse_sender
  import sync_pulse_sender_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 reset,
  sync_pulse_sender_if.master bus
);
  state_t           state, state_next;
  logic             ack_sync, ack_pre, in_wait, complete, launch, load, drop;
  logic             pending_valid, pend_valid_next, req_next;
  logic [WIDTH-1:0] pend_data, tx_next;
  bit_sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ack_toggle),
    .q     (ack_sync),
    .q_pre (ack_pre)
  );
  // a send coinciding with completion and an empty slot launches directly instead of stranding in the slot
  always_comb begin
    in_wait         = state == WAIT_ACK;
    complete        = in_wait && (ack_sync == bus.req_toggle);
    launch          = (!in_wait && bus.send) || (complete && (pending_valid || bus.send));
    load            = in_wait && bus.send && (pending_valid == complete);
    drop            = in_wait && bus.send && pending_valid && !complete;
    pend_valid_next = load || (pending_valid && !complete);
    state_next      = launch ? WAIT_ACK : complete ? IDLE : state;
    req_next        = bus.req_toggle ^ launch;
    tx_next         = launch ? ((in_wait && pending_valid) ? pend_data : bus.data) : bus.tx_data;
  end
  assign bus.accepted = bus.send && !drop;
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_next;
  end
  // done is registered from next-cycle values so it coincides exactly with complete
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.req_toggle <= 1'b0;
      bus.tx_data    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.overflow   <= 1'b0;
      pending_valid  <= 1'b0;
      pend_data      <= '0;
    end else begin
      bus.req_toggle <= req_next;
      bus.tx_data    <= tx_next;
      bus.busy       <= state_next == WAIT_ACK;
      bus.done       <= (state_next == WAIT_ACK) && (ack_pre == req_next);
      bus.overflow   <= drop;
      pending_valid  <= pend_valid_next;
      pend_data      <= load ? bus.data : pend_data;
    end
  end
endmodule

// File: tb/tb_sync_pulse_sender.sv
// tb_sync_pulse_sender: vector table plus scripted sequences, delivered words checked against a queue
module tb_sync_pulse_sender;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_pulse_sender_if #(.WIDTH(16)) b ();
  sync_pulse_sender_if #(.WIDTH(16)) b3 ();

  sync_pulse_sender #(.WIDTH(16), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(b.master));
  sync_pulse_sender #(.WIDTH(16), .SYNC_STAGES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.master));

  // destination model: echo is req_toggle delayed by 3 destination flops, freezable to hold the echo off
  logic       hold = 1'b0;
  logic [2:0] d1 = '0, d3 = '0;
  always @(posedge clk) begin
    if (reset) begin
      d1 <= '0;
      d3 <= '0;
    end else begin
      if (!hold) d1 <= {d1[1:0], b.req_toggle};
      d3 <= {d3[1:0], b3.req_toggle};
    end
  end
  assign b.ack_toggle  = d1[2];
  assign b3.ack_toggle = d3[2];

  int          n_chk = 0, n_fail = 0;
  int          done_cnt = 0, ovf_cnt = 0, d0, o0;
  logic [15:0] exp_q[$];
  logic        sb_en = 1'b0, prev_req = 1'b0, prev_done = 1'b0, prev_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: each req_toggle flip delivers the next queued word
  always @(negedge clk) begin
    if (sb_en) begin
      if (b.req_toggle !== prev_req) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_extra_delivery: got word %h expected none", b.tx_data);
        end else chk("sb_word", {16'h0, b.tx_data}, {16'h0, exp_q.pop_front()});
      end
      if (b.done) chk("done_width", {31'h0, prev_done}, 0);
      if (b.overflow) chk("overflow_width", {31'h0, prev_ovf}, 0);
      if (b.done) done_cnt <= done_cnt + 1;
      if (b.overflow) ovf_cnt <= ovf_cnt + 1;
    end
    prev_req  <= b.req_toggle;
    prev_done <= b.done;
    prev_ovf  <= b.overflow;
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    sb_en   = 1'b0;
    hold    = 1'b0;
    b.send  = 1'b0;
    b3.send = 1'b0;
    reset   = 1'b1;
    nxt;
    nxt;
    reset = 1'b0;
    exp_q.delete();
    nxt;
    sb_en = 1'b1;
    d0    = done_cnt;
    o0    = ovf_cnt;
  endtask

  typedef struct {
    logic        send;
    logic [15:0] data;
    logic        acc;
    logic        ovf;
    logic        busy;
  } vec_t;
  vec_t tv[5];

  initial begin
    tv[0] = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1};
    tv[2] = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1};
    tv[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    b.send  = 1'b0;
    b.data  = '0;
    b3.send = 1'b0;
    b3.data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    smp;
    chk("rst_req", b.req_toggle, 0);
    chk("rst_tx", b.tx_data, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_ovf", b.overflow, 0);
    chk("rst_acc", b.accepted, 0);

    // single transfer, send in cycle 10
    do_reset;
    b.send = 1'b1;
    b.data = 16'h1234;
    exp_q.push_back(16'h1234);
    smp;
    chk("t1_accepted", b.accepted, 1);
    nxt;
    b.send = 1'b0;
    for (int k = 11; k <= 17; k++) begin
      smp;
      chk("t1_done", b.done, k == 16);
      chk("t1_busy", b.busy, k < 17);
      if (k == 11) begin
        chk("t1_req", b.req_toggle, 1);
        chk("t1_tx", b.tx_data, 16'h1234);
      end
      nxt;
    end
    repeat (5) nxt;
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_ovf_count", ovf_cnt - o0, 0);

    // back-to-back: second word waits in the slot
    do_reset;
    b.send = 1'b1;
    b.data = 16'hAAAA;
    exp_q.push_back(16'hAAAA);
    smp;
    chk("t2_acc_first", b.accepted, 1);
    nxt;
    b.send = 1'b0;
    nxt;
    b.send = 1'b1;
    b.data = 16'h5555;
    exp_q.push_back(16'h5555);
    smp;
    chk("t2_acc_second", b.accepted, 1);
    nxt;
    b.send = 1'b0;
    for (int k = 13; k <= 17; k++) begin
      smp;
      if (k == 16) chk("t2_first_done", b.done, 1);
      if (k == 17) begin
        chk("t2_tx_pending", b.tx_data, 16'h5555);
        chk("t2_req_back", b.req_toggle, 0);
      end
      nxt;
    end
    repeat (15) nxt;
    chk("t2_done_count", done_cnt - d0, 2);
    chk("t2_ovf_count", ovf_cnt - o0, 0);
    chk("t2_drained", exp_q.size(), 0);

    // overflow table with the echo held off
    do_reset;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b.send = tv[i].send;
      b.data = tv[i].data;
      if (tv[i].acc) exp_q.push_back(tv[i].data);
      smp;
      chk($sformatf("t3_acc[%0d]", i), b.accepted, tv[i].acc);
      chk($sformatf("t3_ovf[%0d]", i), b.overflow, tv[i].ovf);
      chk($sformatf("t3_busy[%0d]", i), b.busy, tv[i].busy);
      nxt;
    end
    b.send = 1'b0;
    hold   = 1'b0;
    repeat (25) nxt;
    chk("t3_done_count", done_cnt - d0, 2);
    chk("t3_ovf_count", ovf_cnt - o0, 1);
    chk("t3_drained", exp_q.size(), 0);

    // send lands on the completion cycle while the slot is full
    do_reset;
    b.send = 1'b1;
    b.data = 16'h1111;
    exp_q.push_back(16'h1111);
    nxt;
    b.send = 1'b0;
    nxt;
    b.send = 1'b1;
    b.data = 16'h2222;
    exp_q.push_back(16'h2222);
    nxt;
    b.send = 1'b0;
    repeat (3) nxt;
    b.send = 1'b1;
    b.data = 16'h3333;
    exp_q.push_back(16'h3333);
    smp;
    chk("t4_done_same_cycle", b.done, 1);
    chk("t4_acc_on_complete", b.accepted, 1);
    nxt;
    b.send = 1'b0;
    repeat (20) nxt;
    chk("t4_done_count", done_cnt - d0, 3);
    chk("t4_ovf_count", ovf_cnt - o0, 0);
    chk("t4_drained", exp_q.size(), 0);

    // reset in the middle of WAIT_ACK abandons the transfer and the pending word
    do_reset;
    b.send = 1'b1;
    b.data = 16'h1111;
    exp_q.push_back(16'h1111);
    nxt;
    b.data = 16'h2222;
    nxt;
    b.send = 1'b0;
    nxt;
    nxt;
    sb_en = 1'b0;
    reset = 1'b1;
    nxt;
    reset = 1'b0;
    smp;
    chk("t5_req", b.req_toggle, 0);
    chk("t5_tx", b.tx_data, 0);
    chk("t5_busy", b.busy, 0);
    chk("t5_done", b.done, 0);
    chk("t5_ovf", b.overflow, 0);
    exp_q.delete();
    nxt;
    sb_en  = 1'b1;
    d0     = done_cnt;
    b.send = 1'b1;
    b.data = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    smp;
    chk("t5_acc_after", b.accepted, 1);
    nxt;
    b.send = 1'b0;
    repeat (15) nxt;
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_tx_after", b.tx_data, 16'h0F0F);
    chk("t5_drained", exp_q.size(), 0);

    // three-stage synchronizer adds one cycle of round trip
    do_reset;
    b3.send = 1'b1;
    b3.data = 16'hBEEF;
    smp;
    chk("s3_acc", b3.accepted, 1);
    nxt;
    b3.send = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      smp;
      chk("s3_done", b3.done, k == 17);
      if (k == 11) chk("s3_tx", b3.tx_data, 16'hBEEF);
      nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
